// File: rtl/tia_hsc_pkg.sv
// Shared constants for the horizontal sync counter and the object position
// counters: LFSR width, decode steps, their LFSR patterns and the line length.
package tia_hsc_pkg;

  localparam int LFSR_W    = 6;
  localparam int LINE_CLKS = 228;

  localparam int STEP_SHB = 0;
  localparam int STEP_SHS = 4;
  localparam int STEP_RHS = 8;
  localparam int STEP_SCB = 8;
  localparam int STEP_RCB = 12;
  localparam int STEP_RHB = 16;
  localparam int STEP_LHB = 18;
  localparam int STEP_CNT = 28;
  localparam int STEP_END = 56;

  // LFSR contents after N advances from 000000 with new bit0 = ~(bit5 ^ bit4)
  localparam logic [LFSR_W-1:0] PAT_00 = 6'b000000;
  localparam logic [LFSR_W-1:0] PAT_04 = 6'b001111;
  localparam logic [LFSR_W-1:0] PAT_08 = 6'b111011;
  localparam logic [LFSR_W-1:0] PAT_12 = 6'b111100;
  localparam logic [LFSR_W-1:0] PAT_16 = 6'b001110;
  localparam logic [LFSR_W-1:0] PAT_18 = 6'b111010;
  localparam logic [LFSR_W-1:0] PAT_28 = 6'b001011;
  localparam logic [LFSR_W-1:0] PAT_56 = 6'b001010;

  // One LFSR advance: shift left, feed back the XNOR of the two top bits
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(v[LFSR_W-1] ^ v[LFSR_W-2])};
  endfunction

endpackage

// File: rtl/tia_lfsr6.sv
// 6-bit XNOR LFSR used as the step counter for horizontal timing.
// clr has priority over adv; the all-ones lock-up state is never reached
// from 000000 within a line.
module tia_lfsr6
  import tia_hsc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv,
  input  logic       clr,
  output logic [5:0] q
);

  // LFSR state: clear wins, otherwise advance when asked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (adv) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/hsync_counter.sv
// Horizontal sync counter: a 2-bit phase counter and a 6-bit LFSR step
// counter (57 steps x 4 clk = 228 clk per line) decoded into one-clk
// set/reset pulses for the HBLANK, HSYNC and colour-burst latches.
// Optional feature macro: HSYNC_HMOVE_EN (late HBLANK release on HMOVE).
module hsync_counter
  import tia_hsc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rsync,
  input  logic hmove,
  output logic shb,
  output logic rhb,
  output logic shs,
  output logic rhs,
  output logic scb,
  output logic rcb,
  output logic cnt,
  output logic line_end
);

  logic [1:0]        ph;
  logic [LFSR_W-1:0] lfsr_q;
  logic              ph_first;
  logic              ph_last;
  logic              wrap;
  logic              dec_shb;
  logic              dec_shs;
  logic              dec_rhs;
  logic              dec_scb;
  logic              dec_rcb;
  logic              dec_16;
  logic              dec_cnt;
  logic              dec_end;
  logic              rhb_d;

  assign ph_first = (ph == 2'd0);
  assign ph_last  = (ph == 2'd3);
  assign wrap     = ph_last && (lfsr_q == PAT_56);

  tia_lfsr6 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (ph_last),
    .clr   (rsync | wrap),
    .q     (lfsr_q)
  );

  // Phase counter: free-running mod 4, restarted by rsync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 2'd0;
    end else if (rsync) begin
      ph <= 2'd0;
    end else begin
      ph <= ph + 2'd1;
    end
  end

  // An rsync edge restarts the line, so nothing is decoded from the old
  // position on that edge; pulses already in the output registers finish.
  assign dec_shb = ph_first && (lfsr_q == PAT_00) && !rsync;
  assign dec_shs = ph_first && (lfsr_q == PAT_04) && !rsync;
  assign dec_rhs = ph_first && (lfsr_q == PAT_08) && !rsync;
  assign dec_scb = ph_first && (lfsr_q == PAT_08) && !rsync;
  assign dec_rcb = ph_first && (lfsr_q == PAT_12) && !rsync;
  assign dec_16  = ph_first && (lfsr_q == PAT_16) && !rsync;
  assign dec_cnt = ph_first && (lfsr_q == PAT_28) && !rsync;
  assign dec_end = wrap && !rsync;

`ifdef HSYNC_HMOVE_EN
  logic dec_18;
  logic hmove_pend;
  logic hmove_carry;
  logic past_16;
  logic hb_late;
  logic hmove_late;

  assign dec_18     = ph_first && (lfsr_q == PAT_18) && !rsync;
  // A strobe on or after the step-16 sample belongs to the next line
  assign hmove_late = hmove && (past_16 || dec_16);

  // HMOVE bookkeeping: pend for this line, carry for the next, late choice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hmove_pend  <= 1'b0;
      hmove_carry <= 1'b0;
      past_16     <= 1'b0;
      hb_late     <= 1'b0;
    end else if (rsync) begin
      hmove_pend  <= 1'b0;
      hmove_carry <= 1'b0;
      past_16     <= 1'b0;
      hb_late     <= 1'b0;
    end else if (dec_end) begin
      hmove_pend  <= hmove_carry | hmove;
      hmove_carry <= 1'b0;
      past_16     <= 1'b0;
      hb_late     <= 1'b0;
    end else begin
      if (hmove && !hmove_late) begin
        hmove_pend <= 1'b1;
      end
      if (hmove_late) begin
        hmove_carry <= 1'b1;
      end
      if (dec_16) begin
        past_16 <= 1'b1;
        hb_late <= hmove_pend;
      end
    end
  end

  assign rhb_d = (dec_16 && !hmove_pend) || (dec_18 && hb_late);
`else
  logic unused_hmove;

  assign unused_hmove = hmove;
  assign rhb_d        = dec_16;
`endif

  // Output pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shb      <= 1'b0;
      rhb      <= 1'b0;
      shs      <= 1'b0;
      rhs      <= 1'b0;
      scb      <= 1'b0;
      rcb      <= 1'b0;
      cnt      <= 1'b0;
      line_end <= 1'b0;
    end else begin
      shb      <= dec_shb;
      rhb      <= rhb_d;
      shs      <= dec_shs;
      rhs      <= dec_rhs;
      scb      <= dec_scb;
      rcb      <= dec_rcb;
      cnt      <= dec_cnt;
      line_end <= dec_end;
    end
  end

endmodule

// File: tb/tb_hsync_counter.sv
// Bench for hsync_counter. The reference model tracks the position in the
// line as a plain edge count (1..228) and derives every pulse from it.
module tb_hsync_counter;

  localparam int SHB = 7, RHB = 6, SHS = 5, RHS = 4, SCB = 3, RCB = 2, CNT = 1, LE = 0;
  localparam int LINE = 228;
`ifdef HSYNC_HMOVE_EN
  localparam bit HM_EN = 1'b1;
`else
  localparam bit HM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rsync = 1'b0;
  logic hmove = 1'b0;
  logic shb, rhb, shs, rhs, scb, rcb, cnt, line_end;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int       k;
  int       abs_edge;
  bit       pend_this, pend_next, late;
  logic [7:0] expv;
  int       ev[8][$];

  always #5 clk = ~clk;

  hsync_counter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rsync    (rsync),
    .hmove    (hmove),
    .shb      (shb),
    .rhb      (rhb),
    .shs      (shs),
    .rhs      (rhs),
    .scb      (scb),
    .rcb      (rcb),
    .cnt      (cnt),
    .line_end (line_end)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, abs_edge, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {shb, rhb, shs, rhs, scb, rcb, cnt, line_end};
  endfunction

  function automatic int ev_at(input int i, input int n);
    if (ev[i].size() > n) return ev[i][n];
    return -1;
  endfunction

  task automatic clear_marks();
    abs_edge = 0;
    for (int i = 0; i < 8; i++) ev[i].delete();
  endtask

  task automatic model_restart();
    k = 0;
    pend_this = 1'b0;
    pend_next = 1'b0;
    late = 1'b0;
  endtask

  // One clock edge with the given strobes, model update and output check
  task automatic tick(input bit rs, input bit hm);
    logic [7:0] o;
    int r;
    rsync = rs;
    hmove = hm;
    @(posedge clk);
    abs_edge++;
    if (rs) begin
      model_restart();
      expv = 8'h00;
    end else begin
      k++;
      r = ((k - 1) % LINE) + 1;
      if (r == 65) late = HM_EN && pend_this;
      expv = 8'h00;
      expv[SHB] = (r == 1);
      expv[RHB] = (r == 65 && !late) || (r == 73 && late);
      expv[SHS] = (r == 17);
      expv[RHS] = (r == 33);
      expv[SCB] = (r == 33);
      expv[RCB] = (r == 49);
      expv[CNT] = (r == 113);
      expv[LE]  = (r == LINE);
      if (HM_EN && hm) begin
        if (r <= 64) pend_this = 1'b1;
        else         pend_next = 1'b1;
      end
      if (r == LINE) begin
        pend_this = pend_next;
        pend_next = 1'b0;
      end
    end
    #1;
    rsync = 1'b0;
    hmove = 1'b0;
    o = outs();
    check("outs", {24'h0, o}, {24'h0, expv});
    check("pairs", {29'h0, o[SHB] & o[RHB], o[SHS] & o[RHS], o[SCB] & o[RCB]}, 32'h0);
    for (int i = 0; i < 8; i++) if (o[i]) ev[i].push_back(abs_edge);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  // Assert reset now (mid-cycle), check immediate clear, release on a negedge
  task automatic apply_reset();
    rsync = 1'b0;
    hmove = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async", {24'h0, outs()}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", {24'h0, outs()}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_restart();
    clear_marks();
  endtask

  task automatic check_first_line(input string tag);
    check({tag, "_shb"}, ev_at(SHB, 0), 1);
    check({tag, "_shs"}, ev_at(SHS, 0), 17);
    check({tag, "_rhs"}, ev_at(RHS, 0), 33);
    check({tag, "_scb"}, ev_at(SCB, 0), 33);
    check({tag, "_rcb"}, ev_at(RCB, 0), 49);
    check({tag, "_rhb"}, ev_at(RHB, 0), 65);
    check({tag, "_cnt"}, ev_at(CNT, 0), 113);
    check({tag, "_le"},  ev_at(LE, 0), 228);
    check({tag, "_shb2"}, ev_at(SHB, 1), 229);
  endtask

  initial begin
    model_restart();
    clear_marks();

    // reset release and free run
    apply_reset();
    run(2 * LINE);
    check_first_line("free");

    // ten lines of free run: constant 228-clk periods
    run(10 * LINE - 2 * LINE);
    check("shb_count", ev[SHB].size(), 10);
    check("le_count", ev[LE].size(), 10);
    for (int i = 1; i < ev[SHB].size(); i++) check("shb_period", ev[SHB][i] - ev[SHB][i-1], LINE);
    for (int i = 1; i < ev[RHB].size(); i++) check("rhb_period", ev[RHB][i] - ev[RHB][i-1], LINE);
    for (int i = 1; i < ev[CNT].size(); i++) check("cnt_period", ev[CNT][i] - ev[CNT][i-1], LINE);
    for (int i = 1; i < ev[LE].size(); i++)  check("le_period",  ev[LE][i]  - ev[LE][i-1],  LINE);

    // hmove at edge 20
    apply_reset();
    run(19);
    tick(1'b0, 1'b1);
    run(2 * LINE - 20);
    check("hmove_rhb0", ev_at(RHB, 0), HM_EN ? 73 : 65);
    check("hmove_rhb1", ev_at(RHB, 1), LINE + 65);

    // hmove at edge 20, then rsync at edge 100 clears the pending request
    apply_reset();
    run(19);
    tick(1'b0, 1'b1);
    run(79);
    tick(1'b1, 1'b0);
    run(200);
    check("rsync_shb", ev_at(SHB, 1), 101);
    check("rsync_shs", ev_at(SHS, 1), 117);
    check("rsync_rhb0", ev_at(RHB, 0), HM_EN ? 73 : 65);
    check("rsync_rhb1", ev_at(RHB, 1), 165);

    // hmove late in the line applies to the following line only
    apply_reset();
    run(99);
    tick(1'b0, 1'b1);
    run(2 * LINE - 100);
    check("late_rhb0", ev_at(RHB, 0), 65);
    check("late_rhb1", ev_at(RHB, 1), HM_EN ? LINE + 73 : LINE + 65);

    // reset pulsed mid-line at edge 40, then sequence repeats
    apply_reset();
    run(40);
    apply_reset();
    run(2 * LINE);
    check_first_line("rst40");

    // reset while cnt pulse is high must clear it at once
    apply_reset();
    run(113);
    check("cnt_before_rst", {31'h0, cnt}, 32'h1);
    apply_reset();
    run(LINE);
    check("rst113_shb", ev_at(SHB, 0), 1);

    // random rsync/hmove traffic against the model
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 499) == 0, $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hsync_counter.md
HSYNC_COUNTER -- requirements
Module: hsync_counter

Interface
REQ-001 SHALL have no parameters; all step and pattern constants SHALL come from the shared package.
REQ-002 clk  input  1  colour clock; one edge per colour clock.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 rsync  input  1  one-clk strobe from the RSYNC register write; restarts the line.
REQ-005 hmove  input  1  one-clk strobe from the HMOVE register write; requests late HBLANK release.
REQ-006 shb, rhb  output  1 each  one-clk set/reset pulses for the HBLANK latch.
REQ-007 shs, rhs  output  1 each  one-clk set/reset pulses for the HSYNC latch.
REQ-008 scb, rcb  output  1 each  one-clk set/reset pulses for the colour-burst latch.
REQ-009 cnt  output  1  one-clk pulse at line centre.
REQ-010 line_end  output  1  one-clk pulse on the last colour clock of the line.

Function
REQ-011 Phase counter ph[1:0] SHALL increment on every clk and wrap 3->0.
REQ-012 The 6-bit LFSR SHALL advance only on edges where ph==3.
- Advance rule: shift left; new bit0 = ~(bit5 ^ bit4).
- Start value: 000000; all-ones is never reached.
REQ-013 When the LFSR holds the step-56 pattern and ph==3, the next value SHALL be 000000, giving 57 steps × 4 = 228 clk per line.
REQ-014 Edge numbering: edge k is the k-th rising clk edge after rst_n deasserts or after the rsync edge.
REQ-015 Every output SHALL be registered; step N's pulse SHALL be high for exactly the one cycle following edge 4N+1.
REQ-016 Decode steps:
- shb 0; shs 4; rhs 8; scb 8; rcb 12.
- rhb 16, or 18 when late HBLANK applies.
- cnt 28; line_end 56 (high after edge 228, i.e. the ph==3 cycle of step 56).
REQ-017 The paired set and reset of one latch SHALL never be high in the same cycle, including across rsync and hmove events.
REQ-018 rsync high at an edge SHALL load ph=0 and LFSR=000000 at that edge, and the following edge SHALL count as edge 1.
- rsync SHALL win over a simultaneous wrap.
- rsync SHALL clear hmove_pend.
- Pulses already registered SHALL complete their single cycle.
REQ-019 An hmove strobe SHALL set hmove_pend.
- hmove_pend SHALL clear on the line_end pulse.
- A set and a clear in the same cycle SHALL resolve to set.
REQ-020 hmove_pend SHALL be sampled at the step-16 decode: if set, rhb is emitted at step 18 and not at step 16.
REQ-021 An hmove arriving after the step-16 decode SHALL take effect on the next line only.

Reset
REQ-022 While rst_n is low: ph=0, LFSR=000000, hmove_pend=0, and every output=0.
REQ-023 rst_n asserted mid-line SHALL clear state immediately, with no completion of pending pulses; counting resumes from edge 1.

Configuration
REQ-024 With HSYNC_HMOVE_EN defined:
- the hmove input is honoured;
- hmove_pend exists;
- REQ-019 to REQ-021 apply.
REQ-025 Without HSYNC_HMOVE_EN:
- hmove is ignored;
- no hmove_pend register is built;
- rhb always fires at step 16.

Structure
REQ-026 Package tia_hsc_pkg SHALL hold:
- LFSR width (6);
- step constants 0, 4, 8, 12, 16, 18, 28, 56;
- the matching precomputed 6-bit LFSR patterns;
- line length 228.
REQ-027 The LFSR SHALL be a sub-module tia_lfsr6 (ports clk, rst_n, adv, clr, q[5:0]), reusable by the object position counters.
REQ-028 Decode SHALL compare the LFSR against package patterns only; no binary step counter SHALL exist in RTL.

Verification
REQ-029 Reset release, free run:
- shb after edge 1; shs after edge 17; rhs and scb after edge 33; rcb after 49; rhb after 65; cnt after 113; line_end after 228;
- shb again after edge 229.
REQ-030 Free run 10 lines: every pulse period SHALL be exactly 228 clk, and no set/reset pair SHALL coincide.
REQ-031 hmove at edge 20 (HSYNC_HMOVE_EN):
- rhb after edge 73, not after 65;
- the next line's rhb after edge 228+65.
REQ-032 rsync at edge 100: shb after edge 101; hmove_pend cleared; the next shs 16 clk later.
REQ-033 rst_n pulsed low at edge 40: all outputs are 0 at once; after release the REQ-029 sequence repeats.
REQ-034 Build without HSYNC_HMOVE_EN, hmove at edge 20: rhb after edge 65.
